// File: rtl/ioctl_loader_pkg.sv
// ioctl_loader_pkg: shared types, constants and helpers for the ioctl download router.
//   - hps_io slot numbers for each target memory
//   - target_t / state_t enums
//   - target decode, address-width and one-hot select helpers
package ioctl_loader_pkg;

    localparam logic [7:0] IDX_BIOS   = 8'd0;
    localparam logic [7:0] IDX_SPRITE = 8'd3;
    localparam logic [7:0] IDX_MUSIC  = 8'd4;

    localparam int IOCTL_AW = 25;
    localparam int MEM_AW   = 17;
    localparam int DATA_W   = 8;
    localparam int COUNT_W  = 18;
    localparam int SEL_W    = 3;

    typedef enum logic [1:0] {
        TGT_NONE   = 2'd0,
        TGT_BIOS   = 2'd1,
        TGT_SPRITE = 2'd2,
        TGT_MUSIC  = 2'd3
    } target_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic target_t index_to_target(input logic [7:0] idx);
        case (idx)
            IDX_BIOS:   return TGT_BIOS;
            IDX_SPRITE: return TGT_SPRITE;
            IDX_MUSIC:  return TGT_MUSIC;
            default:    return TGT_NONE;
        endcase
    endfunction

    // Address width of a target; TGT_NONE returns 0 (callers gate NONE separately).
    function automatic logic [4:0] target_aw(input target_t tgt,
                                             input logic [4:0] bios_aw,
                                             input logic [4:0] sprite_aw,
                                             input logic [4:0] music_aw);
        case (tgt)
            TGT_BIOS:   return bios_aw;
            TGT_SPRITE: return sprite_aw;
            TGT_MUSIC:  return music_aw;
            default:    return 5'd0;
        endcase
    endfunction

    function automatic logic [SEL_W-1:0] target_onehot(input target_t tgt);
        case (tgt)
            TGT_BIOS:   return 3'b001;
            TGT_SPRITE: return 3'b010;
            TGT_MUSIC:  return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/ioctl_loader_if.sv
// ioctl_loader_if: hps_io ioctl byte stream plus the memory write port.
//   master : drives ioctl_* requests and mem_ready (hps_io + memory side)
//   slave  : the loader; drives ioctl_wait and the mem_* write request
interface ioctl_loader_if;
    import ioctl_loader_pkg::*;

    logic                ioctl_download;
    logic [7:0]          ioctl_index;
    logic                ioctl_wr;
    logic [IOCTL_AW-1:0] ioctl_addr;
    logic [DATA_W-1:0]   ioctl_dout;
    logic                ioctl_wait;
    logic                mem_wr;
    logic [SEL_W-1:0]    mem_sel;
    logic [MEM_AW-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_data;
    logic                mem_ready;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ready,
        input  ioctl_wait, mem_wr, mem_sel, mem_addr, mem_data
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ready,
        output ioctl_wait, mem_wr, mem_sel, mem_addr, mem_data
    );
endinterface

// File: rtl/ioctl_loader_fifo.sv
// ioctl_fifo: synchronous FIFO whose head entry is presented from a register.
//   clk, rst_n       : clock, async active-low reset
//   push, push_data  : enqueue (accepted when not full, or when popping in the same cycle)
//   pop              : dequeue the head (ignored when empty)
//   full, empty      : occupancy flags
//   count            : current occupancy
//   head             : registered copy of the oldest entry, valid while !empty
module ioctl_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic [PW:0]      count_nxt_s;
    logic [PW:0]      remain_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_nxt_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == {(PW+1){1'b0}});
    assign count = count_r;
    assign head  = head_r;

    // Accept/retire decisions and the entry that becomes head after this edge.
    // The head register lets the output appear one cycle after the push even when empty.
    always_comb begin
        pop_ok_s    = pop && !empty;
        push_ok_s   = push && (!full || pop_ok_s);
        count_nxt_s = count_r + {{PW{1'b0}}, push_ok_s} - {{PW{1'b0}}, pop_ok_s};
        remain_s    = count_r - {{PW{1'b0}}, pop_ok_s};
        if (remain_s != {(PW+1){1'b0}}) begin
            head_nxt_s = mem_r[rd_ptr_r + {{(PW-1){1'b0}}, pop_ok_s}];
        end else if (push_ok_s) begin
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Storage, pointers, occupancy and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
            head_r   <= {WIDTH{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            count_r <= count_nxt_s;
            head_r  <= head_nxt_s;
        end
    end
endmodule

// File: rtl/ioctl_loader.sv
// ioctl_loader: routes an hps_io download into the BIOS, sprite ROM or YM music memory.
//   clk_sys, reset_n : clock, async active-low reset
//   io (slave)       : ioctl_* byte stream in, ioctl_wait back-pressure, mem_* write port out
//   dl_busy          : download in flight (start until the done pulse)
//   dl_done          : one-cycle completion pulse
//   dl_count, dl_sum : committed byte count (saturating) and mod-256 byte sum
//   dl_overflow      : a byte was dropped (out of range or FIFO full)
module ioctl_loader
    import ioctl_loader_pkg::*;
#(
    parameter int BIOS_AW     = 14,
    parameter int SPRITE_AW   = 15,
    parameter int MUSIC_AW    = 17,
    parameter int FIFO_DEPTH  = 4,
    parameter int WAIT_THRESH = 2
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    ioctl_loader_if.slave      io,
    output logic               dl_busy,
    output logic               dl_done,
    output logic [COUNT_W-1:0] dl_count,
    output logic [DATA_W-1:0]  dl_sum,
    output logic               dl_overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = MEM_AW + DATA_W;

    state_t             state_r;
    state_t             state_nxt;
    target_t            target_r;
    target_t            target_nxt;
    logic               start_s;
    logic [4:0]         aw_s;
    logic               wr_active_s;
    logic               in_range_s;
    logic               range_drop_s;
    logic               push_s;
    logic               push_acc_s;
    logic               pop_s;
    logic [CW-1:0]      occ_nxt_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CW-1:0]      fifo_count_s;
    logic [EW-1:0]      head_s;
    logic               busy_r;
    logic               done_r;
    logic               wait_r;
    logic               mem_wr_r;
    logic [SEL_W-1:0]   sel_r;
    logic [COUNT_W-1:0] count_r;
    logic [DATA_W-1:0]  sum_r;
    logic               ovf_r;

    // Byte acceptance: only in ACTIVE, only for a real target, only inside its window.
    assign aw_s         = target_aw(target_r, 5'(BIOS_AW), 5'(SPRITE_AW), 5'(MUSIC_AW));
    assign wr_active_s  = (state_r == ST_ACTIVE) && io.ioctl_wr;
    assign in_range_s   = (target_r != TGT_NONE) && ((io.ioctl_addr >> aw_s) == 25'd0);
    assign push_s       = wr_active_s && in_range_s;
    assign range_drop_s = wr_active_s && (target_r != TGT_NONE) && !in_range_s;
    assign pop_s        = mem_wr_r && io.mem_ready;
    assign push_acc_s   = push_s && (!fifo_full_s || pop_s);
    assign occ_nxt_s    = fifo_count_s + {{(CW-1){1'b0}}, push_acc_s} - {{(CW-1){1'b0}}, pop_s};

    ioctl_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_sys),
        .rst_n     (reset_n),
        .push      (push_s),
        .push_data ({io.ioctl_addr[MEM_AW-1:0], io.ioctl_dout}),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .head      (head_s)
    );

    // Next-state logic; the target is latched only when a download starts.
    always_comb begin
        state_nxt  = state_r;
        target_nxt = target_r;
        start_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (io.ioctl_download) begin
                    state_nxt  = ST_ACTIVE;
                    target_nxt = index_to_target(io.ioctl_index);
                    start_s    = 1'b1;
                end else begin
                    state_nxt  = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (!io.ioctl_download) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_s && !mem_wr_r) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and latched target registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            target_r <= TGT_NONE;
        end else begin
            state_r  <= state_nxt;
            target_r <= target_nxt;
        end
    end

    // Registered handshake/status outputs, all derived from the post-edge state and occupancy.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            wait_r   <= 1'b0;
            mem_wr_r <= 1'b0;
            sel_r    <= 3'b000;
        end else begin
            busy_r   <= (state_nxt == ST_ACTIVE) || (state_nxt == ST_DRAIN);
            done_r   <= (state_nxt == ST_DONE);
            wait_r   <= (state_nxt == ST_DRAIN) || (state_nxt == ST_DONE) ||
                        (occ_nxt_s >= CW'(WAIT_THRESH));
            mem_wr_r <= (occ_nxt_s != {CW{1'b0}});
            sel_r    <= (state_nxt == ST_IDLE) ? 3'b000 : target_onehot(target_nxt);
        end
    end

    // Per-download statistics; cleared at start, held after DONE until the next start.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {COUNT_W{1'b0}};
            sum_r   <= 8'd0;
            ovf_r   <= 1'b0;
        end else if (start_s) begin
            count_r <= {COUNT_W{1'b0}};
            sum_r   <= 8'd0;
            ovf_r   <= 1'b0;
        end else begin
            if (pop_s) begin
                if (count_r != {COUNT_W{1'b1}}) begin
                    count_r <= count_r + 18'd1;
                end
                sum_r <= sum_r + head_s[DATA_W-1:0];
            end
            if (range_drop_s || (push_s && !push_acc_s)) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign io.ioctl_wait = wait_r;
    assign io.mem_wr     = mem_wr_r;
    assign io.mem_sel    = sel_r;
    assign io.mem_addr   = head_s[EW-1:DATA_W];
    assign io.mem_data   = head_s[DATA_W-1:0];
    assign dl_busy       = busy_r;
    assign dl_done       = done_r;
    assign dl_count      = count_r;
    assign dl_sum        = sum_r;
    assign dl_overflow   = ovf_r;
endmodule

// File: tb/tb_ioctl_loader.sv
// tb_ioctl_loader: directed bench for ioctl_loader with a queue-based expected-write model.
module tb_ioctl_loader;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        dl_busy;
    logic        dl_done;
    logic [17:0] dl_count;
    logic [7:0]  dl_sum;
    logic        dl_overflow;

    ioctl_loader_if bus();

    ioctl_loader dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .io          (bus),
        .dl_busy     (dl_busy),
        .dl_done     (dl_done),
        .dl_count    (dl_count),
        .dl_sum      (dl_sum),
        .dl_overflow (dl_overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [27:0] exp_q[$];
    int unsigned exp_count;
    logic [7:0]  exp_sum;
    logic        exp_ovf;
    int          cur_aw;
    logic [2:0]  cur_sel;
    bit          cur_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Model: a download's target window and the writes it must produce.
    function automatic void model_start(input logic [7:0] idx);
        exp_count = 0;
        exp_sum   = 8'd0;
        exp_ovf   = 1'b0;
        case (idx)
            8'd0:    begin cur_valid = 1'b1; cur_aw = 14; cur_sel = 3'b001; end
            8'd3:    begin cur_valid = 1'b1; cur_aw = 15; cur_sel = 3'b010; end
            8'd4:    begin cur_valid = 1'b1; cur_aw = 17; cur_sel = 3'b100; end
            default: begin cur_valid = 1'b0; cur_aw = 0;  cur_sel = 3'b000; end
        endcase
    endfunction

    function automatic void model_wr(input logic [24:0] a, input logic [7:0] d);
        if (cur_valid) begin
            if (a < (25'd1 << cur_aw)) begin
                exp_q.push_back({cur_sel, a[16:0], d});
                exp_count++;
                exp_sum += d;
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endfunction

    // Compare process: every completed write, stall stability, and end-of-download stats.
    logic       held_vld = 1'b0;
    logic [28:0] held;
    always @(negedge clk_sys) begin
        if (reset_n !== 1'b1) begin
            held_vld = 1'b0;
        end else begin
            if (held_vld)
                chk("stall_stable", {bus.mem_wr, bus.mem_sel, bus.mem_addr, bus.mem_data}, held);
            if (bus.mem_wr && bus.mem_ready) begin
                if (exp_q.size() == 0) chk("unexpected_wr", bus.mem_wr, 0);
                else chk("mem_write", {bus.mem_sel, bus.mem_addr, bus.mem_data}, exp_q.pop_front());
            end
            held_vld = bus.mem_wr && !bus.mem_ready;
            held     = {bus.mem_wr, bus.mem_sel, bus.mem_addr, bus.mem_data};
            if (dl_done) begin
                chk("done_count", dl_count, exp_count);
                chk("done_sum", dl_sum, exp_sum);
                chk("done_ovf", dl_overflow, exp_ovf);
                chk("done_busy", dl_busy, 0);
                chk("done_wait", bus.ioctl_wait, 1);
                chk("done_q_empty", exp_q.size(), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = idx;
        model_start(idx);
        tick();
        chk("start_busy", dl_busy, 1);
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d);
        int n = 0;
        while (bus.ioctl_wait && n < 50) begin
            tick();
            n++;
        end
        chk("wait_release", bus.ioctl_wait, 0);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        model_wr(a, d);
        tick();
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (dl_done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("done_pulse", dl_done, 1);
    endtask

    task automatic after_done(input logic [17:0] cnt);
        tick();
        chk("done_one_cycle", dl_done, 0);
        chk("idle_busy", dl_busy, 0);
        chk("count_hold", dl_count, cnt);
    endtask

    initial begin
        int sent;
        reset_n            = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_dout     = 8'd0;
        bus.mem_ready      = 1'b1;
        tick();
        chk("rst_outputs", {bus.ioctl_wait, bus.mem_wr, bus.mem_sel, bus.mem_addr, bus.mem_data,
                            dl_busy, dl_done, dl_count, dl_sum, dl_overflow}, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // BIOS: 16 bytes, one write per cycle, latency 1.
        start_dl(8'd0);
        for (int i = 0; i < 16; i++) begin
            send(25'(i), 8'(i));
            chk("lat1_wr", bus.mem_wr, 1);
            chk("lat1_addr", bus.mem_addr, i);
            chk("lat1_data", bus.mem_data, i);
            chk("lat1_sel", bus.mem_sel, 3'b001);
        end
        bus.ioctl_download = 1'b0;
        wait_done();
        chk("bios_count", dl_count, 16);
        chk("bios_sum", dl_sum, 8'h78);
        chk("bios_ovf", dl_overflow, 0);
        after_done(18'd16);

        // Sprite: out-of-range and high-bit addresses dropped, never aliased.
        start_dl(8'd3);
        send(25'h0008000, 8'h55);
        send(25'h1000001, 8'h77);
        send(25'h0007FFF, 8'hAA);
        bus.ioctl_download = 1'b0;
        wait_done();
        chk("spr_count", dl_count, 1);
        chk("spr_sum", dl_sum, 8'hAA);
        chk("spr_ovf", dl_overflow, 1);
        after_done(18'd1);

        // Music: target stalls, bench honours ioctl_wait.
        start_dl(8'd4);
        bus.mem_ready = 1'b0;
        sent = 0;
        for (int k = 0; k < 10; k++) begin
            if (!bus.ioctl_wait) begin
                bus.ioctl_wr   = 1'b1;
                bus.ioctl_addr = 25'h10000 + 25'(sent);
                bus.ioctl_dout = 8'h30 + 8'(sent);
                model_wr(bus.ioctl_addr, bus.ioctl_dout);
                sent++;
            end else begin
                bus.ioctl_wr = 1'b0;
            end
            tick();
        end
        bus.ioctl_wr = 1'b0;
        chk("stall_accepted", sent, 2);
        chk("stall_wait", bus.ioctl_wait, 1);
        chk("stall_head", {bus.mem_wr, bus.mem_sel, bus.mem_addr, bus.mem_data},
            {1'b1, 3'b100, 17'h10000, 8'h30});
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 40 && sent < 6; k++) begin
            if (!bus.ioctl_wait) begin
                bus.ioctl_wr   = 1'b1;
                bus.ioctl_addr = 25'h10000 + 25'(sent);
                bus.ioctl_dout = 8'h30 + 8'(sent);
                model_wr(bus.ioctl_addr, bus.ioctl_dout);
                sent++;
            end else begin
                bus.ioctl_wr = 1'b0;
            end
            tick();
        end
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        wait_done();
        chk("mus_count", dl_count, 6);
        chk("mus_sum", dl_sum, 8'h2F);
        after_done(18'd6);

        // Unknown index: download runs, nothing written.
        start_dl(8'd7);
        for (int i = 0; i < 5; i++) begin
            send(25'(i), 8'h90 + 8'(i));
            chk("none_wr", bus.mem_wr, 0);
            chk("none_sel", bus.mem_sel, 0);
        end
        bus.ioctl_download = 1'b0;
        wait_done();
        chk("none_count", dl_count, 0);
        after_done(18'd0);

        // Async reset with three queued entries, then a clean restart.
        start_dl(8'd0);
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'h20 + 25'(k);
            bus.ioctl_dout = 8'hC0 + 8'(k);
            model_wr(bus.ioctl_addr, bus.ioctl_dout);
            tick();
        end
        bus.ioctl_wr = 1'b0;
        chk("pre_rst_wr", bus.mem_wr, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst", {bus.ioctl_wait, bus.mem_wr, bus.mem_sel, bus.mem_addr, bus.mem_data,
                          dl_busy, dl_done, dl_count, dl_sum, dl_overflow}, 0);
        exp_q.delete();
        bus.ioctl_download = 1'b0;
        bus.mem_ready      = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        start_dl(8'd0);
        send(25'd1, 8'h05);
        send(25'd2, 8'h06);
        bus.ioctl_download = 1'b0;
        wait_done();
        chk("rst_count", dl_count, 2);
        chk("rst_sum", dl_sum, 8'h0B);
        after_done(18'd2);

        // Final byte with the download fall, stalled drain, re-rise during DRAIN.
        start_dl(8'd0);
        bus.mem_ready = 1'b0;
        send(25'd5, 8'h11);
        bus.ioctl_wr       = 1'b1;
        bus.ioctl_addr     = 25'd6;
        bus.ioctl_dout     = 8'h22;
        bus.ioctl_download = 1'b0;
        model_wr(25'd6, 8'h22);
        tick();
        bus.ioctl_wr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("drain_busy", dl_busy, 1);
            chk("drain_no_done", dl_done, 0);
            chk("drain_wait", bus.ioctl_wait, 1);
            if (k == 1) begin
                bus.ioctl_download = 1'b1;
                bus.ioctl_index    = 8'd3;
            end
            tick();
        end
        bus.mem_ready = 1'b1;
        wait_done();
        chk("fall_count", dl_count, 2);
        chk("fall_sum", dl_sum, 8'h33);
        tick();
        model_start(8'd3);
        chk("rerise_idle", dl_busy, 0);
        tick();
        chk("rerise_active", dl_busy, 1);
        chk("rerise_cleared", dl_count, 0);
        send(25'h10, 8'h01);
        bus.ioctl_download = 1'b0;
        wait_done();
        chk("rerise_count", dl_count, 1);
        after_done(18'd1);

        chk("final_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ioctl_loader.md
Name: ioctl_loader

Overview:
- Download router between hps_io's ioctl_* interface and the memory write ports inside `system`.
- Decodes ioctl_index into a target memory: BIOS, sprite ROM or YM music.
- Buffers bytes in a small FIFO and back-pressures hps_io via ioctl_wait when the target port stalls.
- Reports per-download byte count, 8-bit additive checksum, overflow flag and a completion pulse, so `system` can gate reset and start music playback.

Parameters:
- BIOS_AW, 14, address width of BIOS target; writes at addr >= 2^BIOS_AW are dropped.
- SPRITE_AW, 15, address width of sprite ROM target.
- MUSIC_AW, 17, address width of YM music target.
- FIFO_DEPTH, 4, FIFO entries (power of two, >= 4).
- WAIT_THRESH, 2, FIFO occupancy at or above which ioctl_wait asserts.

Ports:
- clk_sys  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download slot: 0=BIOS, 3=sprite, 4=music.
- ioctl_wr  in  1  byte strobe, one-cycle pulse.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  back-pressure to hps_io.
- mem_wr  out  1  write request to the selected target.
- mem_sel  out  3  one-hot target: [0]=BIOS, [1]=sprite, [2]=music.
- mem_addr  out  17  write address, zero-extended.
- mem_data  out  8  write data.
- mem_ready  in  1  target accepts; a write completes on a cycle with mem_wr & mem_ready.
- dl_busy  out  1  high from download start until the done pulse.
- dl_done  out  1  one-cycle completion pulse.
- dl_count  out  18  bytes committed in the current/last download.
- dl_sum  out  8  mod-256 sum of committed bytes.
- dl_overflow  out  1  at least one byte dropped for range.

Behaviour:
- Reset (async assert, sync deassert inside block):
  - State IDLE; FIFO empty.
  - All outputs 0: ioctl_wait, mem_wr, mem_sel, mem_addr, mem_data, dl_busy, dl_done, dl_count, dl_sum, dl_overflow.
- States: IDLE, ACTIVE, DRAIN, DONE.
- IDLE:
  - On ioctl_download=1, latch ioctl_index into a target code and clear dl_count, dl_sum and dl_overflow.
  - Go to ACTIVE and set dl_busy=1.
  - An unknown index gives target NONE; the download still runs but no byte is ever queued.
- ACTIVE:
  - Each ioctl_wr queues {addr[16:0], data} when target != NONE and addr < 2^AW(target).
  - A write with addr >= 2^AW (including bits [24:17] nonzero) is dropped and sets dl_overflow. It is not counted or summed.
  - If ioctl_download falls, go to DRAIN.
  - A wr arriving in the same cycle as the fall is still processed.
- DRAIN: when the FIFO is empty and no mem_wr is outstanding, go to DONE.
- DONE:
  - dl_done=1 for exactly one cycle; dl_busy drops in the same cycle; return to IDLE.
  - dl_count, dl_sum and dl_overflow hold until the next download starts.
- Outside ACTIVE, ioctl_wr is ignored.
- If ioctl_download re-rises during DRAIN or DONE, it is sampled in IDLE the next cycle (level-sensitive start). ioctl_wait is held 1 throughout DRAIN and DONE.
- FIFO:
  - Simultaneous push and pop is allowed and occupancy is unchanged.
  - ioctl_wait is registered: 1 when occupancy >= WAIT_THRESH.
  - A push while full is dropped and sets dl_overflow; it cannot happen when hps_io honours wait within 1 cycle.
- Memory side:
  - mem_wr, mem_addr, mem_data and mem_sel come from the FIFO head, registered.
  - First mem_wr is one cycle after the push (latency 1 from ioctl_wr when the FIFO is empty).
  - mem_addr, mem_data and mem_sel stay stable while mem_wr=1 and mem_ready=0.
  - On mem_wr & mem_ready: pop, dl_count += 1 (saturating at 2^18-1), dl_sum += data (wraps mod 256).
  - Back-to-back writes at 1 per cycle when mem_ready stays high.
- mem_sel is the latched target one-hot; it is 0 when target is NONE or in IDLE.
- Address wrap: none. Out-of-range bytes are always dropped, never aliased.

Decomposition:
- Package ioctl_loader_pkg holds:
  - index constants IDX_BIOS=0, IDX_SPRITE=3, IDX_MUSIC=4;
  - target_t enum {TGT_NONE, TGT_BIOS, TGT_SPRITE, TGT_MUSIC};
  - state_t enum;
  - function target_aw(target_t).
- One sub-module, ioctl_fifo: synchronous FIFO with push, pop, full, empty and count, async active-low reset.

Test Plan:
- Index 0, 16 bytes 0x00..0x0F at addr 0..15, mem_ready=1: mem_sel=3'b001, mem_wr one cycle after each wr, in order; dl_done pulse; dl_count=16, dl_sum=0x78, dl_overflow=0.
- Index 3 write at addr 0x8000 (>= 2^15) plus addr 0x7FFF data 0xAA: only 0x7FFF written; dl_count=1, dl_sum=0xAA, dl_overflow=1.
- Index 4, mem_ready held 0 for 10 cycles with writes every cycle: ioctl_wait=1 once occupancy hits 2; no data lost when the bench obeys wait; all bytes are delivered in order after ready=1; mem_* stable while stalled.
- Index 7, 5 writes: mem_wr never asserts; dl_count=0, dl_done still pulses.
- reset_n low mid-download with 3 entries queued: all outputs 0 immediately (async); after release, a new index-0 download starts clean with dl_count counting from 0.
- ioctl_download falls with a simultaneous final wr and mem_ready=0 for 4 cycles: that byte is written; dl_done fires only after the FIFO drains; re-rise during DRAIN starts the next download right after DONE.
